// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage pipeline.
//
// This module owns the program counter and presents it as a byte address to
// the instruction memory. The memory returns a 32-bit instruction word
// combinationally. That word is captured into the IF/ID register together with
// the unwrapped PC+4 and a valid flag.
//
// Control inputs:
//   - stall (from the hazard unit) holds both the PC and IF/ID.
//   - redirect (from EX) reloads the PC and flushes IF/ID. Redirect has
//     priority over stall.
//
// When the fetched word is the self-loop halt word, fetch freezes.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low (0 = reset)
//   stall         hold PC and IF/ID
//   redirect      taken branch/jump resolved in EX this cycle
//   redirect_pc   branch/jump target byte address
//   imem_addr     byte address to instruction memory (= pc)
//   imem_instr    instruction word for imem_addr (combinational)
//   ifid_instr    IF/ID instruction word
//   ifid_pc4      IF/ID PC+4 of that instruction (unwrapped)
//   ifid_valid    IF/ID holds a real instruction
//   halted        fetch frozen on the halt word
//   misalign_err  sticky flag: a redirect target with nonzero low bits was seen
//   fetch_count   instructions accepted into IF/ID, saturating
module fetch_stage #(
    parameter int          MEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] HALT_WORD = 32'hA800FFFF,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MEM_MASK = 32'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] halt_pc_q,     halt_pc_d;
    logic [31:0] ifid_instr_q,  ifid_instr_d;
    logic [31:0] ifid_pc4_q,    ifid_pc4_d;
    logic        ifid_valid_q,  ifid_valid_d;
    logic        halted_q,      halted_d;
    logic        misalign_q,    misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] redirect_tgt;

    // ifid_pc4 keeps the full unwrapped sum so EX target math is unaffected.
    // Only the next fetch address wraps modulo MEM_BYTES.
    assign pc_plus4     = pc_q + 32'd4;
    assign pc_next      = pc_plus4 & MEM_MASK;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00} & MEM_MASK;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        halt_pc_d     = halt_pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_valid_d  = ifid_valid_q;
        halted_d      = halted_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            // One dead cycle after reset lets the instruction memory settle.
            ST_BOOT: begin
                ifid_instr_d = NOP_WORD;
                ifid_pc4_d   = 32'd0;
                ifid_valid_d = 1'b0;
                state_d      = ST_RUN;
            end

            ST_RUN: begin
                if (redirect) begin
                    pc_d         = redirect_tgt;
                    ifid_instr_d = NOP_WORD;
                    ifid_pc4_d   = 32'd0;
                    ifid_valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_instr_d = imem_instr;
                    ifid_pc4_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_next;
                    if (fetch_count_q != 32'hFFFF_FFFF) begin
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                    // The halt word itself still issues; only the PC freezes on it.
                    if (imem_instr == HALT_WORD) begin
                        state_d   = ST_HALT;
                        halt_pc_d = pc_q;
                        pc_d      = pc_q;
                        halted_d  = 1'b1;
                    end
                end
            end

            ST_HALT: begin
                if (redirect) begin
                    ifid_instr_d = NOP_WORD;
                    ifid_pc4_d   = 32'd0;
                    ifid_valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                    // A redirect back to the halt word is the self-jump resolving.
                    // Any other target means the halt word was fetched on a wrong path.
                    if (redirect_pc != halt_pc_q) begin
                        halted_d = 1'b0;
                        state_d  = ST_RUN;
                        pc_d     = redirect_tgt;
                    end
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            halt_pc_q     <= RESET_PC;
            ifid_instr_q  <= NOP_WORD;
            ifid_pc4_q    <= 32'd0;
            ifid_valid_q  <= 1'b0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            halt_pc_q     <= halt_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_valid_q  <= ifid_valid_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_pc4     = ifid_pc4_q;
    assign ifid_valid   = ifid_valid_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule
